// File: rtl/qspi_pkg.sv
// qspi_pkg: shared FSM encoding, opcodes, mode nibbles and address width for the QSPI flash emulator
package qspi_pkg;
    localparam int ADDR_W = 24;
    localparam logic [7:0] OP_QREAD = 8'hEB;
    localparam logic [7:0] OP_SREAD = 8'h03;
    localparam logic [3:0] MODE_XIP_ON = 4'hA;
    localparam logic [3:0] MODE_XIP_OFF = 4'hF;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, QDATA, SDATA, HALT} state_t;
endpackage

// File: rtl/qspi_edge_sync.sv
// qspi_edge_sync: 2-flop synchroniser with rise/fall pulses on the synchronised level
module qspi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr <= {3{RST_VAL}};
        else         sr <= {sr[1:0], d};
    end
    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/qspi_flash_emu.sv
// qspi_flash_emu: QSPI read-only flash emulator (0xEB quad I/O with XIP, 0x03 single read)
// backed by a word store loaded through a backdoor port.
module qspi_flash_emu
    import qspi_pkg::*;
#(
    parameter int         MEM_WORDS = 2048,
    parameter int         DUMMY_CYC = 4,
    parameter logic [7:0] CMD_QREAD = OP_QREAD,
    parameter logic [7:0] CMD_SREAD = OP_SREAD
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         qspi_ck_o,
    input  logic                         qspi_cs_o,
    input  logic [3:0]                   qspi_io_o,
    input  logic [3:0]                   qspi_io_t,
    output logic [3:0]                   qspi_io_i,
    input  logic                         ld_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr_i,
    input  logic [31:0]                  ld_wdata_i,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [7:0]                   err_cmd_o
);
    localparam int WA = $clog2(MEM_WORDS);
    logic sck_rise, sck_fall, sck_unused, cs_q, cs_rise, cs_fall;
    logic [3:0] io_s1, io_s2, t_s1, t_s2, smp, mask, io_q, mode_sr;
    logic [1:0] settle;
    logic armed, xip, quad, nib, err, op_ok;
    logic [2:0] bidx;
    logic [6:0] cmd_sr;
    logic [7:0] cmd_full, cnt, cur, err_cmd;
    logic [ADDR_W-1:0] addr;
    logic [31:0] word;
    logic [31:0] mem [MEM_WORDS];
    state_t state;

    qspi_edge_sync #(.RST_VAL(1'b0)) u_sck (
        .clk_i(clk_i), .rst_ni(rst_ni), .d(qspi_ck_o), .q(sck_unused), .rise(sck_rise), .fall(sck_fall)
    );
    qspi_edge_sync #(.RST_VAL(1'b1)) u_cs (
        .clk_i(clk_i), .rst_ni(rst_ni), .d(qspi_cs_o), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {io_s1, io_s2, t_s1, t_s2} <= '0;
        end else begin
            {io_s1, io_s2} <= {qspi_io_o, io_s1};
            {t_s1, t_s2}   <= {qspi_io_t, t_s1};
        end
    end

    // A CS low that straddles reset must not start a frame; arm only once CS is seen high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (settle == 2'd3 && cs_q) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_we_i && !busy_o) mem[ld_addr_i] <= ld_wdata_i;
    end

    assign word     = mem[addr[WA+1:2]];
    assign cur      = word[{addr[1:0], 3'b000} +: 8];
    assign smp      = io_s2 & ~t_s2;
    assign mask     = (state == MODE || (state == ADDR && quad)) ? 4'hF :
                      (state == CMD || state == ADDR) ? 4'h1 : 4'h0;
    assign cmd_full = {cmd_sr, smp[0]};
    assign op_ok    = cmd_full == CMD_QREAD || cmd_full == CMD_SREAD;
    assign busy_o    = state != IDLE && !cs_q;
    assign qspi_io_i = io_q;
    assign err_o     = err;
    assign err_cmd_o = err_cmd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            xip     <= 1'b0;
            quad    <= 1'b0;
            nib     <= 1'b0;
            bidx    <= '0;
            cnt     <= '0;
            cmd_sr  <= '0;
            mode_sr <= '0;
            addr    <= '0;
            io_q    <= '0;
            err     <= 1'b0;
            err_cmd <= '0;
        end else begin
            if ((ld_we_i && busy_o) || (sck_rise && |(t_s2 & mask))) err <= 1'b1;
            if (cs_rise) begin
                state <= IDLE;
                io_q  <= '0;
            end else if (cs_fall && armed) begin
                state <= xip ? ADDR : CMD;
                quad  <= xip;
                cnt   <= '0;
                nib   <= 1'b0;
                bidx  <= '0;
                addr  <= '0;
            end else if (sck_rise) begin
                case (state)
                    CMD: begin
                        cmd_sr <= cmd_full[6:0];
                        cnt    <= cnt + 8'd1;
                        if (cnt == 8'd7) begin
                            cnt   <= '0;
                            quad  <= cmd_full == CMD_QREAD;
                            state <= op_ok ? ADDR : HALT;
                            if (!op_ok) err <= 1'b1;
                            if (!op_ok && !err) err_cmd <= cmd_full;
                        end
                    end
                    ADDR: begin
                        addr <= quad ? {addr[ADDR_W-5:0], smp} : {addr[ADDR_W-2:0], smp[0]};
                        cnt  <= cnt + 8'd1;
                        if (cnt == (quad ? 8'd5 : 8'd23)) begin
                            cnt   <= '0;
                            state <= quad ? MODE : SDATA;
                        end
                    end
                    MODE: begin
                        mode_sr <= smp;
                        cnt     <= cnt + 8'd1;
                        if (cnt == 8'd1) begin
                            cnt <= '0;
                            if (mode_sr == MODE_XIP_ON || mode_sr == MODE_XIP_OFF) begin
                                xip   <= mode_sr == MODE_XIP_ON;
                                state <= DUMMY_CYC == 0 ? QDATA : DUMMY;
                            end else begin
                                state <= HALT;
                                err   <= 1'b1;
                                if (!err) err_cmd <= {mode_sr, smp};
                            end
                        end
                    end
                    DUMMY: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(DUMMY_CYC - 1)) begin
                            cnt   <= '0;
                            state <= QDATA;
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall) begin
                if (state == QDATA) begin
                    io_q <= nib ? cur[3:0] : cur[7:4];
                    nib  <= ~nib;
                    if (nib) addr <= addr + ADDR_W'(1);
                end
                if (state == SDATA) begin
                    io_q <= {2'b00, cur[~bidx], 1'b0};
                    bidx <= bidx + 3'd1;
                    if (bidx == 3'd7) addr <= addr + ADDR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_flash_emu.sv
// tb_qspi_flash_emu: bus-level bench driving a QSPI controller model; expected nibbles
// come from a local copy of the loaded words and are queued before each read phase.
module tb_qspi_flash_emu;
    logic clk = 1'b0, rst_n = 1'b0, ck = 1'b0, cs = 1'b1, ld_we = 1'b0;
    logic [3:0] io_o = 4'h0, io_t = 4'hF, io_i;
    logic [10:0] ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic busy, err;
    logic [7:0] err_cmd;
    logic [31:0] model [2048];
    logic [3:0] sb [$];
    int n_cmp = 0, n_bad = 0;

    qspi_flash_emu dut (
        .clk_i(clk), .rst_ni(rst_n), .qspi_ck_o(ck), .qspi_cs_o(cs), .qspi_io_o(io_o),
        .qspi_io_t(io_t), .qspi_io_i(io_i), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
        .ld_wdata_i(ld_wdata), .busy_o(busy), .err_o(err), .err_cmd_o(err_cmd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [23:0] a);
        logic [31:0] w;
        w = model[a[12:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic load(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        @(negedge clk);
        ld_we = 1'b0;
        model[a] = d;
    endtask

    task automatic sck(input logic [3:0] d, input logic [3:0] t);
        io_o = d; io_t = t;
        #50 ck = 1'b1;
        #50 ck = 1'b0;
    endtask

    task automatic get(output logic [3:0] v);
        io_t = 4'hF;
        #50 v = io_i;
        ck = 1'b1;
        #50 ck = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck({3'b000, b[i]}, 4'hE);
    endtask

    task automatic frame_hdr(input bit op, input logic [23:0] a, input logic [7:0] m);
        cs = 1'b0;
        #100;
        if (op) send_op(8'hEB);
        for (int i = 5; i >= 0; i--) sck(a[4*i +: 4], 4'h0);
        sck(m[7:4], 4'h0);
        sck(m[3:0], 4'h0);
        repeat (4) sck(4'h0, 4'hF);
    endtask

    task automatic push_bytes(input logic [23:0] a, input int nb);
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            b = mbyte(a + 24'(i));
            sb.push_back(b[7:4]);
            sb.push_back(b[3:0]);
        end
    endtask

    task automatic drain(input string tag, input int n);
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            get(v);
            check(tag, v, sb.pop_front());
        end
    endtask

    task automatic stop();
        #50 cs = 1'b1;
        #200;
    endtask

    task automatic quad_read(input string tag, input bit op, input logic [23:0] a, input logic [7:0] m, input int nb);
        frame_hdr(op, a, m);
        check({tag, "_busy"}, busy, 1);
        push_bytes(a, nb);
        drain(tag, 2 * nb);
        stop();
    endtask

    task automatic single_read(input string tag, input logic [23:0] a, input int nbits);
        logic [7:0] b;
        cs = 1'b0;
        #100;
        send_op(8'h03);
        for (int i = 23; i >= 0; i--) sck({3'b000, a[i]}, 4'hE);
        for (int i = 0; i < nbits; i++) begin
            b = mbyte(a + 24'(i / 8));
            sb.push_back({2'b00, b[7 - i % 8], 1'b0});
        end
        drain(tag, nbits);
        stop();
    endtask

    initial begin
        #100;
        check("rst_io", io_i, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_cmd", err_cmd, 0);
        rst_n = 1'b1;
        #100;
        load(11'd0, 32'h44332211);
        load(11'd1, 32'hDDCCBBAA);
        load(11'd2, 32'h5A6B7C8D);
        load(11'd2047, 32'h88776655);

        quad_read("q_basic", 1, 24'h000000, 8'hF0, 4);
        check("q_basic_xip", dut.xip, 0);
        check("q_basic_err", err, 0);

        quad_read("xip_set", 1, 24'h000000, 8'hA0, 2);
        check("xip_on", dut.xip, 1);
        quad_read("xip_frame", 0, 24'h000004, 8'hF0, 4);
        check("xip_off", dut.xip, 0);
        quad_read("post_xip", 1, 24'h000008, 8'hF0, 2);
        check("post_xip_busy_idle", busy, 0);

        single_read("s_read", 24'h000001, 16);
        check("s_read_err", err, 0);

        quad_read("wrap", 1, 24'h001FFE, 8'hF0, 4);
        check("wrap_err", err, 0);

        cs = 1'b0;
        #100;
        send_op(8'h9F);
        #100;
        check("bad_op_err", err, 1);
        check("bad_op_cmd", err_cmd, 8'h9F);
        check("halt_busy", busy, 1);
        repeat (3) sb.push_back(4'h0);
        drain("halt_io", 3);
        stop();
        check("halt_idle", busy, 0);
        quad_read("after_err", 1, 24'h000000, 8'hF0, 2);
        check("err_sticky", err, 1);
        check("err_cmd_kept", err_cmd, 8'h9F);

        frame_hdr(1, 24'h000000, 8'hF0);
        push_bytes(24'h000000, 1);
        push_bytes(24'h000001, 1);
        void'(sb.pop_back());
        drain("pre_rst", 3);
        rst_n = 1'b0;
        #1;
        check("midrst_io", io_i, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        #40 rst_n = 1'b1;
        #60;
        repeat (4) sb.push_back(4'h0);
        drain("post_rst_io", 4);
        check("post_rst_busy", busy, 0);
        stop();
        check("post_rst_idle", busy, 0);

        frame_hdr(1, 24'h000000, 8'hF0);
        check("drop_busy", busy, 1);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 11'd0; ld_wdata = 32'hDEADBEEF;
        @(negedge clk);
        ld_we = 1'b0;
        check("drop_err", err, 1);
        push_bytes(24'h000000, 4);
        drain("drop_in_frame", 8);
        stop();
        quad_read("drop_kept", 1, 24'h000000, 8'hF0, 4);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
